rom_fetch_unit: RTL
===================

Name: rom_fetch_unit

Overview:
- Initiator side of the synchronous instruction ROM interface. It drives ROM addresses, absorbs the ROM's one-cycle read latency, and buffers fetched bytes in a small FIFO.
- Bytes are presented to the processor core over a valid/ready stream, each tagged with its address.
- Supports redirect (jump) with flush of all buffered and in-flight data.
- Sits between the ROM (CLK, ADDR[7:0] in, DATA[7:0] registered out) and the processor decode logic.

Parameters:
- ADDR_WIDTH, 8, ROM address width; the fetch pointer wraps modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 8, ROM word width.
- FIFO_DEPTH, 4, prefetch buffer entries; power of 2, minimum 2.
- RESET_ADDR, 8'h00, fetch pointer value after reset.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- ROM_ADDR  out  ADDR_WIDTH  address to ROM; equals the fetch pointer register.
- ROM_DATA  in  DATA_WIDTH  ROM output; holds mem[ADDR sampled at previous edge].
- JUMP_EN  in  1  redirect request, sampled at the rising edge.
- JUMP_ADDR  in  ADDR_WIDTH  redirect target.
- INSTR_DATA  out  DATA_WIDTH  FIFO head data.
- INSTR_ADDR  out  ADDR_WIDTH  address the head byte was fetched from.
- INSTR_VALID  out  1  FIFO non-empty.
- INSTR_READY  in  1  consumer accepts the head when INSTR_VALID is high.
- FIFO_LEVEL  out  clog2(FIFO_DEPTH)+1  current occupancy, for debug.

Behaviour:
- Reset (edge with RESET=1):
  - fetch_ptr=RESET_ADDR; inflight=0; FIFO emptied.
  - INSTR_VALID=0, INSTR_DATA=0, INSTR_ADDR=0, FIFO_LEVEL=0.
  - RESET overrides JUMP_EN and INSTR_READY.
- Issue:
  - issue = !JUMP_EN && (FIFO_LEVEL + inflight < FIFO_DEPTH). This is a credit check that ignores a same-cycle pop.
  - On an edge with issue=1: ROM latches mem[fetch_ptr]; fetch_ptr<=fetch_ptr+1 (wraps FF->00); inflight<=1; inflight_addr<=fetch_ptr.
  - On an edge with issue=0: inflight<=0.
- Capture: on an edge with inflight=1 (and no jump/reset), push {inflight_addr, ROM_DATA} into the FIFO. ROM_DATA is ignored when inflight=0.
- Pop: on an edge with INSTR_VALID && INSTR_READY, the head advances. Push and pop may occur on the same edge; level is unchanged.
- Stall stability: while INSTR_VALID && !INSTR_READY, INSTR_DATA and INSTR_ADDR hold.
- No-op input: INSTR_READY with INSTR_VALID=0 has no effect.
- Jump (edge with JUMP_EN=1):
  - FIFO emptied; inflight<=0, so the ROM_DATA of the pending read is discarded; fetch_ptr<=JUMP_ADDR.
  - A concurrent pop is cancelled (the consumer must treat the byte as not taken); a concurrent push is dropped.
- Latency:
  - After a jump or reset edge E0: ROM_ADDR=J after E0; ROM read at E1; push at E2.
  - INSTR_VALID=1 with mem[J], INSTR_ADDR=J after E2 (2 cycles).
- Throughput: 1 byte/cycle sustained when the consumer keeps INSTR_READY=1 and FIFO_DEPTH>=3.
- Full: FIFO_LEVEL+inflight never exceeds FIFO_DEPTH. With READY=0, issue stops; level settles at FIFO_DEPTH with no overflow; ROM_ADDR holds the next unfetched address.
- Wrap: after address 8'hFF, the next fetched address is 8'h00; INSTR_ADDR tags follow the same wrap.
- Assertions: no push when full; no pop when empty; FIFO_LEVEL<=FIFO_DEPTH.

Test Plan:
- Bench ROM model: registered read with mem[a]=a^8'hA5.
- Reset then READY=1 constant -> first INSTR_VALID 2 cycles after reset release, with INSTR_ADDR=00, DATA=A5. Then 01/A4, 02/A7, ... one per cycle with no gaps.
- READY=0 for 10 cycles after reset -> FIFO_LEVEL reaches 4 and stays; ROM_ADDR=04; head holds 00/A5. On READY=1, drain 00..03 and continue 04/A1 without any skip or duplicate.
- JUMP_EN=1, JUMP_ADDR=8'h40 mid-stream with READY=1 -> no stale byte after the jump edge. Exactly 2 cycles later, head is 40/E5, then 41/E4.
- JUMP_ADDR=8'hFE, READY=1 -> sequence FE/5B, FF/5A, 00/A5, 01/A4.
- RESET asserted while FIFO holds 3 entries and JUMP_EN=1 -> after the edge: INSTR_VALID=0, FIFO_LEVEL=0, ROM_ADDR=RESET_ADDR; the jump is ignored.
- Random READY toggling over 1000 cycles with random jumps -> every accepted byte has DATA==INSTR_ADDR^A5. Addresses are consecutive between jumps, and each post-jump sequence starts at JUMP_ADDR.

Source files
------------

// File: rtl/rom_fetch_unit.sv
// Prefetching initiator for a synchronous ROM: issues sequential reads, absorbs the
// one-cycle read latency and streams address-tagged bytes through a small FIFO.
module rom_fetch_unit #(
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    DATA_WIDTH = 8,
   parameter int                    FIFO_DEPTH = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
   input  logic                          CLK,
   input  logic                          RESET,
   output logic [ADDR_WIDTH-1:0]         ROM_ADDR,
   input  logic [DATA_WIDTH-1:0]         ROM_DATA,
   input  logic                          JUMP_EN,
   input  logic [ADDR_WIDTH-1:0]         JUMP_ADDR,
   output logic [DATA_WIDTH-1:0]         INSTR_DATA,
   output logic [ADDR_WIDTH-1:0]         INSTR_ADDR,
   output logic                          INSTR_VALID,
   input  logic                          INSTR_READY,
   output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;

   logic [ADDR_WIDTH-1:0] fetch_ptr_q, fetch_ptr_d;
   logic                  inflight_q, inflight_d;
   logic [ADDR_WIDTH-1:0] inflight_addr_q, inflight_addr_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]         level_q, level_d;

   logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];

   logic                  issue;
   logic                  push;
   logic                  pop;
   logic [LW:0]           occupancy;

   // Credits count the pending ROM read as occupied so the FIFO can never overflow.
   assign occupancy = {1'b0, level_q} + {{LW{1'b0}}, inflight_q};
   assign issue     = !JUMP_EN && (occupancy < (LW+1)'(FIFO_DEPTH));
   assign push      = inflight_q && !JUMP_EN;
   assign pop       = (level_q != '0) && INSTR_READY && !JUMP_EN;

   always_comb begin
      fetch_ptr_d     = fetch_ptr_q;
      inflight_d      = 1'b0;
      inflight_addr_d = inflight_addr_q;
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      level_d         = level_q;

      if (JUMP_EN) begin
         fetch_ptr_d = JUMP_ADDR;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         level_d     = '0;
      end else begin
         if (issue) begin
            fetch_ptr_d     = fetch_ptr_q + ADDR_WIDTH'(1);
            inflight_d      = 1'b1;
            inflight_addr_d = fetch_ptr_q;
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         fetch_ptr_q     <= RESET_ADDR;
         inflight_q      <= 1'b0;
         inflight_addr_q <= '0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         level_q         <= '0;
      end else begin
         fetch_ptr_q     <= fetch_ptr_d;
         inflight_q      <= inflight_d;
         inflight_addr_q <= inflight_addr_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         level_q         <= level_d;
      end
   end

   // Storage needs no reset: an entry is only visible once its level slot is counted.
   always_ff @(posedge CLK) begin
      if (push && !RESET) begin
         fifo_data_q[wr_ptr_q] <= ROM_DATA;
         fifo_addr_q[wr_ptr_q] <= inflight_addr_q;
      end
   end

   assign ROM_ADDR    = fetch_ptr_q;
   assign INSTR_VALID = (level_q != '0);
   assign INSTR_DATA  = INSTR_VALID ? fifo_data_q[rd_ptr_q] : '0;
   assign INSTR_ADDR  = INSTR_VALID ? fifo_addr_q[rd_ptr_q] : '0;
   assign FIFO_LEVEL  = level_q;

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         assert (!(push && !pop && level_q == LW'(FIFO_DEPTH)));
         assert (!(pop && level_q == '0));
         assert (level_q <= LW'(FIFO_DEPTH));
      end
   end

endmodule
